// File: rtl/three_req_arbiter.sv
// Round-robin arbiter granting one shared resource to requesters A/B/C, with optional hold-limit preemption.
// Latency: request high before an arbitration edge -> registered grant after that edge (1 cycle).
// Backpressure: none; requests are levels, not queued, and a grant ends with one idle turnaround cycle.
//
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   inA, inB, inC  : request levels, indices 0, 1 and 2
//   gnt            : registered one-hot grant (bit0=A, bit1=B, bit2=C)
//   busy           : OR of the gnt bits
//   owner          : index of the current or last owner, 2'b11 until the first grant
//   hold_cnt       : 0-based count of cycles the current grant has been held; saturates
`timescale 1ns/1ps
module three_req_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inA,
  input  logic              inB,
  input  logic              inC,
  output logic [2:0]        gnt,
  output logic              busy,
  output logic [1:0]        owner,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

  logic [1:0] state;
  logic [1:0] last;
  logic [2:0] req;

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic       pickVld;
  logic [1:0] pickIdx;
  logic [2:0] pickOneHot;

  logic ownerReq;
  logic othersReq;
  logic holdExpired;

  assign req  = {inC, inB, inA};
  assign busy = |gnt;

  // Search order is last+1, last+2, last (mod 3): the previous owner is always
  // considered last, which is what rotates priority after a release or a preemption.
  always_comb begin
    cand1      = (last == 2'd2) ? 2'd0 : last + 2'd1;
    cand2      = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    pickVld    = 1'b1;
    pickIdx    = last;
    if (req[cand1]) begin
      pickIdx = cand1;
    end else if (req[cand2]) begin
      pickIdx = cand2;
    end else if (req[last]) begin
      pickIdx = last;
    end else begin
      pickVld = 1'b0;
    end
    pickOneHot = 3'(3'b001 << pickIdx);
  end

  // gnt is one-hot while in GRANT, so masking req with it isolates the owner.
  assign ownerReq    = |(req & gnt);
  assign othersReq   = |(req & ~gnt);
  assign holdExpired = PREEMPT_EN && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      owner    <= 2'b11;
      last     <= 2'd2;
      hold_cnt <= '0;
    end else begin
      case (state)
        GRANT: begin
          // Any release goes through TURN so the bus is never handed over directly.
          if (!ownerReq || (holdExpired && othersReq)) begin
            state    <= TURN;
            gnt      <= 3'b000;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          // IDLE and TURN arbitrate identically; TURN simply lasts one cycle.
          if (pickVld) begin
            state    <= GRANT;
            gnt      <= pickOneHot;
            owner    <= pickIdx;
            last     <= pickIdx;
            hold_cnt <= '0;
          end else begin
            state    <= IDLE;
            gnt      <= 3'b000;
            hold_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_three_req_arbiter.sv
`timescale 1ns/1ps
module tb_three_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic inA, inB, inC;

  // Three instances sharing the same requests: MAX_HOLD = 4, 8 and 0 (unlimited).
  logic [2:0] gntW   [3];
  logic       busyW  [3];
  logic [1:0] ownerW [3];
  logic [3:0] holdW  [3];

  three_req_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .inC(inC),
    .gnt(gntW[0]), .busy(busyW[0]), .owner(ownerW[0]), .hold_cnt(holdW[0]));
  three_req_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .inC(inC),
    .gnt(gntW[1]), .busy(busyW[1]), .owner(ownerW[1]), .hold_cnt(holdW[1]));
  three_req_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .inA(inA), .inB(inB), .inC(inC),
    .gnt(gntW[2]), .busy(busyW[2]), .owner(ownerW[2]), .hold_cnt(holdW[2]));

  int checks = 0;
  int errors = 0;

  int maxHoldTab [3] = '{4, 8, 0};

  // Reference model: who holds the resource (-1 = nobody), how many cycles
  // they have held it (1 in the first grant cycle), the last owner for rotation
  // and the reported owner (3 = none since reset).
  int         mGrantee [3];
  int         mHeld    [3];
  int         mLast    [3];
  int         mOwner   [3];
  logic [2:0] prevGnt  [3];

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mGrantee[k] = -1;
      mHeld[k]    = 0;
      mLast[k]    = 2;
      mOwner[k]   = 3;
      prevGnt[k]  = 3'b000;
    end
  endtask

  task automatic modelStep(input int k, input logic [2:0] req);
    int  g;
    int  c;
    bit  others;
    bit  found;
    if (mGrantee[k] >= 0) begin
      g      = mGrantee[k];
      others = (req & ~(3'b001 << g)) != 3'b000;
      if (!req[g] || (maxHoldTab[k] != 0 && mHeld[k] == maxHoldTab[k] && others)) begin
        mGrantee[k] = -1;
        mHeld[k]    = 0;
      end else begin
        mHeld[k]++;
      end
    end else begin
      found = 1'b0;
      for (int off = 1; off <= 3; off++) begin
        c = (mLast[k] + off) % 3;
        if (!found && req[c]) begin
          found       = 1'b1;
          mGrantee[k] = c;
          mLast[k]    = c;
          mOwner[k]   = c;
          mHeld[k]    = 1;
        end
      end
    end
  endtask

  function automatic int expGnt(input int k);
    return (mGrantee[k] >= 0) ? (1 << mGrantee[k]) : 0;
  endfunction

  function automatic int expHold(input int k);
    if (mGrantee[k] < 0) return 0;
    return (mHeld[k] - 1 > 15) ? 15 : mHeld[k] - 1;
  endfunction

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      checkEq($sformatf("gnt[%0d]", k),   32'(gntW[k]),   32'(expGnt(k)));
      checkEq($sformatf("busy[%0d]", k),  32'(busyW[k]),  32'(expGnt(k) != 0));
      checkEq($sformatf("owner[%0d]", k), 32'(ownerW[k]), 32'(mOwner[k]));
      checkEq($sformatf("hold[%0d]", k),  32'(holdW[k]),  32'(expHold(k)));
      checkEq($sformatf("onehot0[%0d]", k), 32'($onehot0(gntW[k])), 32'd1);
      checkEq($sformatf("noDirectSwap[%0d]", k),
              32'(prevGnt[k] == 3'b000 || gntW[k] == 3'b000 || gntW[k] == prevGnt[k]), 32'd1);
      prevGnt[k] = gntW[k];
    end
  endtask

  // Inputs change only on the falling edge; outputs are checked on the falling edge.
  task automatic tick();
    logic [2:0] req;
    @(posedge clk);
    req = {inC, inB, inA};
    if (rst_n) begin
      for (int k = 0; k < 3; k++) modelStep(k, req);
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic setReq(input logic [2:0] r);
    {inC, inB, inA} = r;
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    modelReset();
  endtask

  int rrSeq [16] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 1};

  initial begin
    modelReset();
    rst_n = 1'b0;
    setReq(3'b001);
    @(negedge clk);

    // Reset held with inA high: nothing granted.
    repeat (3) tick();
    checkEq("resetOwner", 32'(ownerW[0]), 32'd3);
    rst_n = 1'b1;
    tick();
    checkEq("releaseGntA", 32'(gntW[0]), 32'd1);
    checkEq("releaseOwnerA", 32'(ownerW[0]), 32'd0);

    // Single requester B: never preempted, counter saturates.
    setReq(3'b000);
    repeat (2) tick();
    setReq(3'b010);
    repeat (20) tick();
    checkEq("soleBgnt", 32'(gntW[1]), 32'd2);
    checkEq("soleBsat", 32'(holdW[1]), 32'd15);
    setReq(3'b000);
    tick();
    checkEq("soleBturn", 32'(gntW[1]), 32'd0);
    tick();

    // All three requesting from reset.
    assertReset();
    setReq(3'b111);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkEq($sformatf("rr4_%0d", i), 32'(gntW[0]), 32'(rrSeq[i]));
      checkEq($sformatf("unlimA_%0d", i), 32'(gntW[2]), 32'd1);
    end
    // Unlimited hold: A keeps it for 30 cycles, then TURN, then B.
    repeat (14) tick();
    checkEq("unlimA30", 32'(gntW[2]), 32'd1);
    setReq(3'b110);
    tick();
    checkEq("unlimTurn", 32'(gntW[2]), 32'd0);
    tick();
    checkEq("unlimB", 32'(gntW[2]), 32'd2);

    // Voluntary release: A owns two cycles while C waits.
    assertReset();
    setReq(3'b000);
    tick();
    rst_n = 1'b1;
    setReq(3'b101);
    tick();
    checkEq("volA1", 32'(gntW[0]), 32'd1);
    tick();
    checkEq("volA2", 32'(gntW[0]), 32'd1);
    setReq(3'b100);
    tick();
    checkEq("volTurn", 32'(gntW[0]), 32'd0);
    tick();
    checkEq("volC", 32'(gntW[0]), 32'd4);

    // Asynchronous reset in the middle of C's grant.
    #2;
    assertReset();
    #1;
    checkEq("asyncGnt", 32'(gntW[0]), 32'd0);
    checkEq("asyncBusy", 32'(busyW[0]), 32'd0);
    checkEq("asyncOwner", 32'(ownerW[0]), 32'd3);
    setReq(3'b011);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkEq("postAsyncA", 32'(gntW[0]), 32'd1);

    // Randomized request traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) inA = ~inA;
      if ($urandom_range(0, 3) == 0) inB = ~inB;
      if ($urandom_range(0, 3) == 0) inC = ~inC;
      if ($urandom_range(0, 299) == 0) begin
        assertReset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
